// File: rtl/ariane_pkg.sv
// Shared types and sizing constants for the issue scoreboard: entry record,
// exception record and transaction-ID width.
package ariane_pkg;

    localparam int NR_SB_ENTRIES = 4;
    localparam int TRANS_ID_BITS = 3;
    localparam int NR_WB_PORTS   = 2;

    localparam logic [63:0] LD_ACCESS_FAULT = 64'd5;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_LOAD,
        FU_STORE,
        FU_BRANCH,
        FU_MULT,
        FU_CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception                 ex;
    } scoreboard_entry;

    function automatic logic is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/issue/write-back/commit/forwarding signals of the issue scoreboard.
// The scoreboard sits on the slave side; the pipeline around it is the master.
interface issue_scoreboard_if #(
    parameter int NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
);
    import ariane_pkg::*;

    logic                                        flush_i;
    logic                                        full_o;
    scoreboard_entry                             decoded_instr_i;
    logic                                        decoded_instr_valid_i;
    logic                                        decoded_instr_ack_o;
    scoreboard_entry                             issue_instr_o;
    logic                                        issue_instr_valid_o;
    logic                                        issue_ack_i;
    logic [4:0]                                  rs1_i;
    logic [4:0]                                  rs2_i;
    logic [63:0]                                 rs1_o;
    logic [63:0]                                 rs2_o;
    logic                                        rs1_match_o;
    logic                                        rs2_match_o;
    logic                                        rs1_valid_o;
    logic                                        rs2_valid_o;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_i;
    logic [NR_WB_PORTS-1:0][63:0]                wdata_i;
    exception [NR_WB_PORTS-1:0]                  ex_i;
    logic [NR_WB_PORTS-1:0]                      wb_valid_i;
    scoreboard_entry                             commit_instr_o;
    logic                                        commit_valid_o;
    logic                                        commit_ack_i;

    modport slave (
        input  flush_i, decoded_instr_i, decoded_instr_valid_i, issue_ack_i,
               rs1_i, rs2_i, trans_id_i, wdata_i, ex_i, wb_valid_i, commit_ack_i,
        output full_o, decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
               rs1_o, rs2_o, rs1_match_o, rs2_match_o, rs1_valid_o, rs2_valid_o,
               commit_instr_o, commit_valid_o
    );

    modport master (
        output flush_i, decoded_instr_i, decoded_instr_valid_i, issue_ack_i,
               rs1_i, rs2_i, trans_id_i, wdata_i, ex_i, wb_valid_i, commit_ack_i,
        input  full_o, decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
               rs1_o, rs2_o, rs1_match_o, rs2_match_o, rs1_valid_o, rs2_valid_o,
               commit_instr_o, commit_valid_o
    );

endinterface

// File: rtl/sb_operand_lookup.sv
// Youngest-producer search over issued, occupied scoreboard entries for one
// source register; returns the hit flag, its result-valid bit and its result.
module sb_operand_lookup #(
    parameter int NR_ENTRIES = 4
) (
    input  logic [$clog2(NR_ENTRIES)-1:0] commit_ptr,
    input  logic [$clog2(NR_ENTRIES):0]   count,
    input  logic [NR_ENTRIES-1:0]         issued,
    input  logic [NR_ENTRIES-1:0][4:0]    rd_vec,
    input  logic [NR_ENTRIES-1:0]         valid_vec,
    input  logic [NR_ENTRIES-1:0][63:0]   result_vec,
    input  logic [4:0]                    rs,
    output logic                          match,
    output logic                          valid,
    output logic [63:0]                   result
);

    localparam int PTR_W = $clog2(NR_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk from the head (oldest) towards the tail so the last hit is the youngest.
    always_comb begin
        match  = 1'b0;
        valid  = 1'b0;
        result = '0;
        idx    = '0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            idx = commit_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && issued[idx] && (rs != 5'd0) && (rd_vec[idx] == rs)) begin
                match  = 1'b1;
                valid  = valid_vec[idx];
                result = result_vec[idx];
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: circular buffer fed by decode, drained in order by
// issue and commit, filled out of order by the write-back ports.
module issue_scoreboard #(
    parameter int NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
    parameter int NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    issue_scoreboard_if.slave      sb
);
    import ariane_pkg::*;

    localparam int PTR_W = $clog2(NR_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    if (!is_pow2(NR_ENTRIES) || (NR_ENTRIES > 2 ** TRANS_ID_BITS)) begin : g_bad_depth
        $error("issue_scoreboard: NR_ENTRIES must be a power of two within the transaction-ID range");
    end

    logic [PTR_W-1:0]   commit_ptr_reg;
    logic [PTR_W-1:0]   issue_ptr_reg;
    logic [PTR_W-1:0]   decode_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    scoreboard_entry              entries [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]        issued;
    logic [NR_ENTRIES-1:0][4:0]   rd_vec;
    logic [NR_ENTRIES-1:0]        valid_vec;
    logic [NR_ENTRIES-1:0][63:0]  result_vec;

    logic            full;
    logic            push;
    logic            issue_valid;
    logic            issue_fire;
    logic            commit_valid;
    logic            pop;
    scoreboard_entry decode_entry;

    assign full         = (count_reg == CNT_W'(NR_ENTRIES));
    assign push         = sb.decoded_instr_valid_i & ~full;
    assign issue_valid  = (issue_ptr_reg != decode_ptr_reg) |
                          (full & ~issued[issue_ptr_reg]);
    assign issue_fire   = sb.issue_ack_i & issue_valid;
    assign commit_valid = (count_reg != '0) & entries[commit_ptr_reg].valid;
    assign pop          = sb.commit_ack_i & commit_valid;
    assign count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);

    // The slot index doubles as the transaction ID write-back uses to find it.
    always_comb begin
        decode_entry          = sb.decoded_instr_i;
        decode_entry.trans_id = TRANS_ID_BITS'(decode_ptr_reg);
        decode_entry.valid    = 1'b0;
    end

    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
        scoreboard_entry entry_reg;
        logic            issued_reg;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_reg  <= '0;
                issued_reg <= 1'b0;
            end else if (sb.flush_i) begin
                entry_reg.valid <= 1'b0;
                issued_reg      <= 1'b0;
            end else begin
                if (push && (decode_ptr_reg == PTR_W'(gi))) begin
                    entry_reg  <= decode_entry;
                    issued_reg <= 1'b0;
                end
                // Later ports override earlier ones on an ID collision.
                for (int p = 0; p < NR_WB_PORTS; p++) begin
                    if (sb.wb_valid_i[p] && (sb.trans_id_i[p] == TRANS_ID_BITS'(gi))) begin
                        entry_reg.result <= sb.wdata_i[p];
                        entry_reg.valid  <= 1'b1;
                        if (sb.ex_i[p].valid) begin
                            entry_reg.ex <= sb.ex_i[p];
                        end
                    end
                end
                if (issue_fire && (issue_ptr_reg == PTR_W'(gi))) begin
                    issued_reg <= 1'b1;
                end
                if (pop && (commit_ptr_reg == PTR_W'(gi))) begin
                    issued_reg <= 1'b0;
                end
            end
        end

        assign entries[gi]    = entry_reg;
        assign issued[gi]     = issued_reg;
        assign rd_vec[gi]     = entry_reg.rd;
        assign valid_vec[gi]  = entry_reg.valid;
        assign result_vec[gi] = entry_reg.result;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            commit_ptr_reg <= '0;
            issue_ptr_reg  <= '0;
            decode_ptr_reg <= '0;
            count_reg      <= '0;
        end else if (sb.flush_i) begin
            commit_ptr_reg <= '0;
            issue_ptr_reg  <= '0;
            decode_ptr_reg <= '0;
            count_reg      <= '0;
        end else begin
            if (push) begin
                decode_ptr_reg <= decode_ptr_reg + 1'b1;
            end
            if (issue_fire) begin
                issue_ptr_reg <= issue_ptr_reg + 1'b1;
            end
            if (pop) begin
                commit_ptr_reg <= commit_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    sb_operand_lookup #(
        .NR_ENTRIES (NR_ENTRIES)
    ) i_rs1_lookup (
        .commit_ptr (commit_ptr_reg),
        .count      (count_reg),
        .issued     (issued),
        .rd_vec     (rd_vec),
        .valid_vec  (valid_vec),
        .result_vec (result_vec),
        .rs         (sb.rs1_i),
        .match      (sb.rs1_match_o),
        .valid      (sb.rs1_valid_o),
        .result     (sb.rs1_o)
    );

    sb_operand_lookup #(
        .NR_ENTRIES (NR_ENTRIES)
    ) i_rs2_lookup (
        .commit_ptr (commit_ptr_reg),
        .count      (count_reg),
        .issued     (issued),
        .rd_vec     (rd_vec),
        .valid_vec  (valid_vec),
        .result_vec (result_vec),
        .rs         (sb.rs2_i),
        .match      (sb.rs2_match_o),
        .valid      (sb.rs2_valid_o),
        .result     (sb.rs2_o)
    );

    assign sb.full_o              = full;
    assign sb.decoded_instr_ack_o = push;
    assign sb.issue_instr_o       = entries[issue_ptr_reg];
    assign sb.issue_instr_valid_o = issue_valid;
    assign sb.commit_instr_o      = entries[commit_ptr_reg];
    assign sb.commit_valid_o      = commit_valid;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: issue and commit responses are checked
// by monitors against queues filled by the stimulus; flags are checked inline.
module tb_issue_scoreboard;
    import ariane_pkg::*;

    logic clk;
    logic rst_n;

    issue_scoreboard_if #(.NR_WB_PORTS(2)) sbif ();

    issue_scoreboard #(
        .NR_ENTRIES  (4),
        .NR_WB_PORTS (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sb     (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tid;
        logic [4:0] rd;
    } iss_exp_t;

    typedef struct {
        logic [2:0]  tid;
        logic [63:0] result;
        logic [63:0] cause;
    } cmt_exp_t;

    iss_exp_t issue_q[$];
    cmt_exp_t commit_q[$];
    iss_exp_t ie;
    cmt_exp_t ce;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic scoreboard_entry mk(input logic [4:0] rd);
        scoreboard_entry e;
        e          = '0;
        e.pc       = 64'h1000 + 64'(rd) * 4;
        e.fu       = FU_ALU;
        e.rd       = rd;
        e.rs1      = 5'd1;
        e.trans_id = 3'h7;   // must be replaced by the slot index
        e.valid    = 1'b1;   // must be cleared on entry
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        sbif.decoded_instr_valid_i = 1'b0;
        sbif.issue_ack_i           = 1'b0;
        sbif.wb_valid_i            = '0;
        sbif.ex_i                  = '0;
        sbif.commit_ack_i          = 1'b0;
        sbif.flush_i               = 1'b0;
        sbif.rs1_i                 = '0;
        sbif.rs2_i                 = '0;
    endtask

    task automatic decode(input logic [4:0] rd);
        sbif.decoded_instr_i       = mk(rd);
        sbif.decoded_instr_valid_i = 1'b1;
    endtask

    task automatic issue(input logic [2:0] tid, input logic [4:0] rd);
        sbif.issue_ack_i = 1'b1;
        issue_q.push_back('{tid: tid, rd: rd});
    endtask

    task automatic commit(input logic [2:0] tid, input logic [63:0] res, input logic [63:0] cause);
        sbif.commit_ack_i = 1'b1;
        commit_q.push_back('{tid: tid, result: res, cause: cause});
    endtask

    task automatic wb(input int port, input logic [2:0] id, input logic [63:0] data,
                      input logic exv, input logic [63:0] cause);
        sbif.wb_valid_i[port]    = 1'b1;
        sbif.trans_id_i[port]    = id;
        sbif.wdata_i[port]       = data;
        sbif.ex_i[port].valid    = exv;
        sbif.ex_i[port].cause    = cause;
        sbif.ex_i[port].tval     = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n && sbif.issue_instr_valid_o && sbif.issue_ack_i) begin
            if (issue_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got tid %0d, expected none", sbif.issue_instr_o.trans_id);
            end else begin
                ie = issue_q.pop_front();
                check("issue_tid", 64'(sbif.issue_instr_o.trans_id), 64'(ie.tid));
                check("issue_rd", 64'(sbif.issue_instr_o.rd), 64'(ie.rd));
                $display("issue  tid=%0d rd=%0d", sbif.issue_instr_o.trans_id, sbif.issue_instr_o.rd);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && sbif.commit_valid_o && sbif.commit_ack_i) begin
            if (commit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got tid %0d, expected none", sbif.commit_instr_o.trans_id);
            end else begin
                ce = commit_q.pop_front();
                check("commit_tid", 64'(sbif.commit_instr_o.trans_id), 64'(ce.tid));
                check("commit_result", sbif.commit_instr_o.result, ce.result);
                check("commit_cause", sbif.commit_instr_o.ex.cause, ce.cause);
                $display("commit tid=%0d result=%h cause=%0d", sbif.commit_instr_o.trans_id,
                         sbif.commit_instr_o.result, sbif.commit_instr_o.ex.cause);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(sbif.wb_valid_i[0] && sbif.wb_valid_i[1] &&
                      (sbif.trans_id_i[0] == sbif.trans_id_i[1])))
                else $error("protocol: two write-backs to one ID in a cycle");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n                      = 1'b0;
        sbif.flush_i               = 1'b0;
        sbif.decoded_instr_i       = '0;
        sbif.decoded_instr_valid_i = 1'b0;
        sbif.issue_ack_i           = 1'b0;
        sbif.rs1_i                 = '0;
        sbif.rs2_i                 = '0;
        sbif.trans_id_i            = '0;
        sbif.wdata_i               = '0;
        sbif.ex_i                  = '0;
        sbif.wb_valid_i            = '0;
        sbif.commit_ack_i          = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_full", 64'(sbif.full_o), 0);
        check("rst_issue_valid", 64'(sbif.issue_instr_valid_o), 0);
        check("rst_commit_valid", 64'(sbif.commit_valid_o), 0);
        check("rst_rs1_match", 64'(sbif.rs1_match_o), 0);
        check("rst_commit_pc", sbif.commit_instr_o.pc, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full; decode is refused while full even with a commit that cycle
        for (int i = 0; i < 4; i++) begin
            decode(5'(i + 1));
            @(negedge clk);
            check("fill_ack", 64'(sbif.decoded_instr_ack_o), 1);
            cycle();
        end
        @(negedge clk);
        check("full_after_4", 64'(sbif.full_o), 1);
        check("issue_valid_full", 64'(sbif.issue_instr_valid_o), 1);
        check("commit_valid_unwritten", 64'(sbif.commit_valid_o), 0);
        wb(0, 3'd0, 64'h11, 1'b0, 64'd0);
        cycle();
        decode(5'd9);
        commit(3'd0, 64'h11, 64'd0);
        @(negedge clk);
        check("ack_when_full", 64'(sbif.decoded_instr_ack_o), 0);
        cycle();
        @(negedge clk);
        check("full_after_commit", 64'(sbif.full_o), 0);
        sbif.flush_i = 1'b1;
        cycle();
        @(negedge clk);
        check("flush_issue_valid", 64'(sbif.issue_instr_valid_o), 0);
        check("flush_commit_valid", 64'(sbif.commit_valid_o), 0);

        // In-order issue and out-of-order write-back
        decode(5'd5);
        cycle();
        decode(5'd6);
        issue(3'd0, 5'd5);
        cycle();
        issue(3'd1, 5'd6);
        cycle();
        @(negedge clk);
        check("issue_caught_up", 64'(sbif.issue_instr_valid_o), 0);
        wb(1, 3'd1, 64'hBEEF, 1'b0, 64'd0);
        cycle();
        @(negedge clk);
        check("commit_wait_head", 64'(sbif.commit_valid_o), 0);
        wb(0, 3'd0, 64'h1234, 1'b0, 64'd0);
        cycle();
        commit(3'd0, 64'h1234, 64'd0);
        cycle();
        commit(3'd1, 64'hBEEF, 64'd0);
        cycle();
        @(negedge clk);
        check("commit_drained", 64'(sbif.commit_valid_o), 0);

        // Forwarding: two producers of x7
        sbif.flush_i = 1'b1;
        cycle();
        decode(5'd7);
        cycle();
        decode(5'd7);
        issue(3'd0, 5'd7);
        sbif.rs1_i = 5'd7;
        @(negedge clk);
        check("fwd_not_issued_match", 64'(sbif.rs1_match_o), 0);
        cycle();
        issue(3'd1, 5'd7);
        cycle();
        wb(0, 3'd0, 64'h99, 1'b0, 64'd0);
        sbif.rs1_i = 5'd7;
        sbif.rs2_i = 5'd7;
        @(negedge clk);
        check("fwd_young_unwritten_match", 64'(sbif.rs1_match_o), 1);
        check("fwd_young_unwritten_valid", 64'(sbif.rs1_valid_o), 0);
        check("fwd_rs2_unwritten_valid", 64'(sbif.rs2_valid_o), 0);
        cycle();
        wb(1, 3'd1, 64'h42, 1'b0, 64'd0);
        sbif.rs1_i = 5'd7;
        @(negedge clk);
        check("fwd_no_bypass_valid", 64'(sbif.rs1_valid_o), 0);
        cycle();
        sbif.rs1_i = 5'd7;
        sbif.rs2_i = 5'd7;
        @(negedge clk);
        check("fwd_rs1_match", 64'(sbif.rs1_match_o), 1);
        check("fwd_rs1_valid", 64'(sbif.rs1_valid_o), 1);
        check("fwd_rs1_data", sbif.rs1_o, 64'h42);
        check("fwd_rs2_data", sbif.rs2_o, 64'h42);
        cycle();
        sbif.rs1_i = 5'd0;
        sbif.rs2_i = 5'd7;
        @(negedge clk);
        check("fwd_x0_match", 64'(sbif.rs1_match_o), 0);
        check("fwd_x0_valid", 64'(sbif.rs1_valid_o), 0);
        check("fwd_x0_data", sbif.rs1_o, 64'h0);
        check("fwd_rs2_still_data", sbif.rs2_o, 64'h42);
        commit(3'd0, 64'h99, 64'd0);
        cycle();
        commit(3'd1, 64'h42, 64'd0);
        cycle();
        sbif.rs1_i = 5'd7;
        @(negedge clk);
        check("fwd_after_commit_match", 64'(sbif.rs1_match_o), 0);
        cycle();

        // Exception carried to commit
        sbif.flush_i = 1'b1;
        cycle();
        decode(5'd3);
        cycle();
        issue(3'd0, 5'd3);
        cycle();
        wb(1, 3'd0, 64'h55, 1'b1, LD_ACCESS_FAULT);
        cycle();
        commit(3'd0, 64'h55, LD_ACCESS_FAULT);
        cycle();

        // Wrap the pointers, then flush concurrently with a decode
        sbif.flush_i = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            decode(5'(i + 1));
            cycle();
            issue(3'(i % 4), 5'(i + 1));
            wb(0, 3'(i % 4), 64'h100 + 64'(i), 1'b0, 64'd0);
            cycle();
            commit(3'(i % 4), 64'h100 + 64'(i), 64'd0);
            cycle();
        end
        sbif.flush_i = 1'b1;
        decode(5'd9);
        cycle();
        decode(5'd10);
        @(negedge clk);
        check("flush_drop_issue_valid", 64'(sbif.issue_instr_valid_o), 0);
        check("flush_drop_commit_valid", 64'(sbif.commit_valid_o), 0);
        check("flush_drop_full", 64'(sbif.full_o), 0);
        cycle();
        issue(3'd0, 5'd10);
        cycle();

        repeat (3) cycle();
        check("issue_queue_drained", 64'(issue_q.size()), 0);
        check("commit_queue_drained", 64'(commit_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
